// File: rtl/ex_muldiv_sequencer.sv
// ex_muldiv_sequencer
// Multi-cycle multiply/divide unit that sits beside the EX stage ALU and
// owns the HI/LO registers. MULT/MULTU use a 32-step shift-add, DIV/DIVU
// a 32-step restoring divide, followed by one sign-fix cycle. MFHI/MFLO
// read HI/LO combinationally; MTHI/MTLO write them when the unit is free.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   i_reset      synchronous active-high reset
//   i_stall      external pipeline stall, blocks acceptance and HI/LO writes
//   i_halt       debug halt, freezes all state
//   i_valid      EX holds an instruction with opcode 000000
//   i_func       function field of that instruction
//   i_op_a       forwarded rs value
//   i_op_b       forwarded rt value
//   o_stall      stall request to the hazard unit
//   o_busy       iteration or sign-fix in progress
//   o_done       one-cycle pulse after HI/LO receive a MULT/DIV result
//   o_div0       sticky flag: last DIV/DIVU had a zero divisor
//   o_hilo_data  HI for MFHI, LO for MFLO, else 0
//   o_hi, o_lo   HI and LO registers
module ex_muldiv_sequencer #(
  parameter int NB_DATA = 32,
  parameter int NB_CNT  = 6
) (
  input  logic               clk,
  input  logic               i_reset,
  input  logic               i_stall,
  input  logic               i_halt,
  input  logic               i_valid,
  input  logic [5:0]         i_func,
  input  logic [NB_DATA-1:0] i_op_a,
  input  logic [NB_DATA-1:0] i_op_b,
  output logic               o_stall,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_div0,
  output logic [NB_DATA-1:0] o_hilo_data,
  output logic [NB_DATA-1:0] o_hi,
  output logic [NB_DATA-1:0] o_lo
);

  localparam logic [5:0] F_MFHI = 6'b010000;
  localparam logic [5:0] F_MTHI = 6'b010001;
  localparam logic [5:0] F_MFLO = 6'b010010;
  localparam logic [5:0] F_MTLO = 6'b010011;
  localparam logic [NB_CNT-1:0] LAST_ITER = NB_CNT'(NB_DATA - 1);

  typedef enum logic [2:0] {ST_IDLE, ST_MUL, ST_DIV, ST_FIX, ST_DONE} state_t;

  state_t               state;
  logic [NB_CNT-1:0]    cnt;
  logic [2*NB_DATA-1:0] acc;
  logic [NB_DATA-1:0]   opnd;
  logic                 is_div;
  logic                 is_div0;
  logic                 neg_lo;
  logic                 neg_hi;
  logic [NB_DATA-1:0]   hi;
  logic [NB_DATA-1:0]   lo;
  logic                 div0;
  logic                 done;

  // Decode of the function field. Bit 1 selects divide, bit 0 selects the
  // unsigned variant, which lets the operand conditioning stay generic.
  logic is_muldiv, is_hilo, op_div, op_signed, unit_free, accept, mt_ok;
  assign is_muldiv = (i_func[5:2] == 4'b0110);
  assign is_hilo   = (i_func[5:2] == 4'b0100);
  assign op_div    = i_func[1];
  assign op_signed = ~i_func[0];
  assign unit_free = (state == ST_IDLE) || (state == ST_DONE);
  assign accept    = unit_free && i_valid && is_muldiv && !i_stall && !i_halt;
  assign mt_ok     = unit_free && i_valid && !i_stall && !i_halt;

  // Magnitudes for signed ops; -2^31 maps onto 0x80000000, which is the
  // correct magnitude when read as unsigned.
  logic a_neg, b_neg;
  logic [NB_DATA-1:0] a_abs, b_abs;
  assign a_neg = op_signed & i_op_a[NB_DATA-1];
  assign b_neg = op_signed & i_op_b[NB_DATA-1];
  assign a_abs = a_neg ? -i_op_a : i_op_a;
  assign b_abs = b_neg ? -i_op_b : i_op_b;

  // Datapath for one iteration. The multiply keeps the partial product in
  // the upper half and the unconsumed multiplier bits in the lower half; the
  // divide keeps remainder on top and the growing quotient below. The trial
  // subtraction is one bit wider than the shifted remainder so its top bit
  // is a clean borrow.
  logic [NB_DATA:0]     mul_sum;
  logic [NB_DATA+1:0]   div_trial;
  logic [2*NB_DATA-1:0] prod_fix;
  logic [NB_DATA-1:0]   q_fix, r_fix;
  assign mul_sum   = {1'b0, acc[2*NB_DATA-1:NB_DATA]} + {1'b0, opnd};
  assign div_trial = {1'b0, acc[2*NB_DATA-1:NB_DATA-1]} - {2'b0, opnd};
  assign prod_fix  = neg_lo ? -acc : acc;
  assign q_fix     = neg_lo ? -acc[NB_DATA-1:0] : acc[NB_DATA-1:0];
  assign r_fix     = neg_hi ? -acc[2*NB_DATA-1:NB_DATA] : acc[2*NB_DATA-1:NB_DATA];

  // Main sequencer. Halt freezes every register including the done pulse.
  // A zero divisor preloads the final HI/LO pattern and jumps straight to
  // FIX, which then copies it out without any sign correction.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      acc     <= '0;
      opnd    <= '0;
      is_div  <= 1'b0;
      is_div0 <= 1'b0;
      neg_lo  <= 1'b0;
      neg_hi  <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      div0    <= 1'b0;
      done    <= 1'b0;
    end else if (!i_halt) begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            cnt     <= '0;
            div0    <= 1'b0;
            is_div  <= op_div;
            is_div0 <= 1'b0;
            if (op_div) begin
              opnd   <= b_abs;
              neg_lo <= a_neg ^ b_neg;
              neg_hi <= a_neg;
              if (i_op_b == '0) begin
                is_div0 <= 1'b1;
                acc     <= {i_op_a, {NB_DATA{1'b1}}};
                state   <= ST_FIX;
              end else begin
                acc   <= {{NB_DATA{1'b0}}, a_abs};
                state <= ST_DIV;
              end
            end else begin
              opnd   <= a_abs;
              acc    <= {{NB_DATA{1'b0}}, b_abs};
              neg_lo <= a_neg ^ b_neg;
              neg_hi <= a_neg ^ b_neg;
              state  <= ST_MUL;
            end
          end else begin
            state <= ST_IDLE;
            if (mt_ok && i_func == F_MTHI) hi <= i_op_a;
            if (mt_ok && i_func == F_MTLO) lo <= i_op_a;
          end
        end
        ST_MUL: begin
          acc <= acc[0] ? {mul_sum, acc[NB_DATA-1:1]}
                        : {1'b0, acc[2*NB_DATA-1:1]};
          cnt <= cnt + 1'b1;
          if (cnt == LAST_ITER) begin
            cnt   <= '0;
            state <= ST_FIX;
          end
        end
        ST_DIV: begin
          if (!div_trial[NB_DATA+1])
            acc <= {div_trial[NB_DATA-1:0], acc[NB_DATA-2:0], 1'b1};
          else
            acc <= {acc[2*NB_DATA-2:0], 1'b0};
          cnt <= cnt + 1'b1;
          if (cnt == LAST_ITER) begin
            cnt   <= '0;
            state <= ST_FIX;
          end
        end
        ST_FIX: begin
          if (is_div0) begin
            hi <= acc[2*NB_DATA-1:NB_DATA];
            lo <= acc[NB_DATA-1:0];
          end else if (is_div) begin
            hi <= r_fix;
            lo <= q_fix;
          end else begin
            hi <= prod_fix[2*NB_DATA-1:NB_DATA];
            lo <= prod_fix[NB_DATA-1:0];
          end
          div0  <= is_div0;
          done  <= 1'b1;
          state <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Stall only while results are still pending; in DONE HI/LO are final.
  logic in_flight;
  assign in_flight = (state == ST_MUL) || (state == ST_DIV) || (state == ST_FIX);
  assign o_stall   = i_valid && in_flight && (is_muldiv || is_hilo);
  assign o_busy    = in_flight;
  assign o_done    = done;
  assign o_div0    = div0;
  assign o_hi      = hi;
  assign o_lo      = lo;

  always_comb begin
    o_hilo_data = '0;
    if (i_valid && i_func == F_MFHI) o_hilo_data = hi;
    if (i_valid && i_func == F_MFLO) o_hilo_data = lo;
  end

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// Directed testbench for ex_muldiv_sequencer. Inputs are driven 1 ns after
// the rising edge and outputs are sampled 1 ns later, well away from the
// next edge. Expected values are hand-computed constants.
module tb_ex_muldiv_sequencer;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_ADD   = 6'b100000;

  logic        clk = 1'b0;
  logic        i_reset, i_stall, i_halt, i_valid;
  logic [5:0]  i_func;
  logic [31:0] i_op_a, i_op_b;
  logic        o_stall, o_busy, o_done, o_div0;
  logic [31:0] o_hilo_data, o_hi, o_lo;

  int checks = 0;
  int errors = 0;

  ex_muldiv_sequencer #(.NB_DATA(32), .NB_CNT(6)) dut (
    .clk         (clk),
    .i_reset     (i_reset),
    .i_stall     (i_stall),
    .i_halt      (i_halt),
    .i_valid     (i_valid),
    .i_func      (i_func),
    .i_op_a      (i_op_a),
    .i_op_b      (i_op_b),
    .o_stall     (o_stall),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_div0      (o_div0),
    .o_hilo_data (o_hilo_data),
    .o_hi        (o_hi),
    .o_lo        (o_lo)
  );

  // 10 ns clock period
  always #5 clk = ~clk;

  // Advance to 1 ns past the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive every input, then let combinational outputs settle
  task automatic applyStimulus(input logic valid, input logic [5:0] func,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic stall, input logic halt);
    i_valid = valid;
    i_func  = func;
    i_op_a  = a;
    i_op_b  = b;
    i_stall = stall;
    i_halt  = halt;
    #1;
  endtask

  // One comparison, counted, with a FAIL line on mismatch
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Present an op for exactly one accept cycle T; returns in cycle T+1
  task automatic issue(input logic [5:0] func, input logic [31:0] a,
                       input logic [31:0] b);
    applyStimulus(1'b1, func, a, b, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  // Wait (bounded) for o_done, starting at cycle T+start_n; checks the
  // cycle index where o_done appears and the busy cycles seen on the way
  task automatic waitDone(input string tag, input int start_n,
                          input int exp_n, input int exp_busy);
    int n;
    int busy_cnt;
    n = start_n;
    busy_cnt = 0;
    while (!o_done && n < 200) begin
      busy_cnt += int'(o_busy);
      tick();
      n++;
    end
    checkOutput({tag, "_latency"}, 64'(n), 64'(exp_n));
    checkOutput({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_busy));
  endtask

  initial begin
    int stall_cnt;

    i_reset = 1'b1;
    applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    tick();
    tick();
    i_reset = 1'b0;
    applyStimulus(1'b1, F_MFHI, 32'd0, 32'd0, 1'b0, 1'b0);
    checkOutput("rst_busy", 64'(o_busy), 64'd0);
    checkOutput("rst_done", 64'(o_done), 64'd0);
    checkOutput("rst_div0", 64'(o_div0), 64'd0);
    checkOutput("rst_stall", 64'(o_stall), 64'd0);
    checkOutput("rst_hi", 64'(o_hi), 64'd0);
    checkOutput("rst_lo", 64'(o_lo), 64'd0);
    checkOutput("rst_hilo_data", 64'(o_hilo_data), 64'd0);
    applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 1'b0, 1'b0);

    // MULTU largest operands
    issue(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    waitDone("multu_max", 1, 34, 33);
    checkOutput("multu_max_hi", 64'(o_hi), 64'hFFFFFFFE);
    checkOutput("multu_max_lo", 64'(o_lo), 64'h00000001);
    tick();
    checkOutput("done_one_pulse", 64'(o_done), 64'd0);

    // MULT with mixed signs, then read back through MFLO/MFHI
    issue(F_MULT, 32'hFFFFFFF9, 32'd6);
    waitDone("mult_neg", 1, 34, 33);
    checkOutput("mult_neg_hi", 64'(o_hi), 64'hFFFFFFFF);
    checkOutput("mult_neg_lo", 64'(o_lo), 64'hFFFFFFD6);
    tick();
    applyStimulus(1'b1, F_MFLO, 32'd0, 32'd0, 1'b0, 1'b0);
    checkOutput("mflo_data", 64'(o_hilo_data), 64'hFFFFFFD6);
    applyStimulus(1'b1, F_MFHI, 32'd0, 32'd0, 1'b0, 1'b0);
    checkOutput("mfhi_data", 64'(o_hilo_data), 64'hFFFFFFFF);
    applyStimulus(1'b1, F_ADD, 32'd0, 32'd0, 1'b0, 1'b0);
    checkOutput("other_func_data", 64'(o_hilo_data), 64'd0);
    applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 1'b0, 1'b0);

    // Signed divides: -17/5 and the overflow corner -2^31/-1
    issue(F_DIV, 32'hFFFFFFEF, 32'd5);
    waitDone("div_neg", 1, 34, 33);
    checkOutput("div_neg_lo", 64'(o_lo), 64'hFFFFFFFD);
    checkOutput("div_neg_hi", 64'(o_hi), 64'hFFFFFFFE);
    tick();
    issue(F_DIV, 32'h80000000, 32'hFFFFFFFF);
    waitDone("div_ovf", 1, 34, 33);
    checkOutput("div_ovf_lo", 64'(o_lo), 64'h80000000);
    checkOutput("div_ovf_hi", 64'(o_hi), 64'h00000000);
    tick();

    // Divide by zero, sticky flag, cleared by the next accept
    issue(F_DIVU, 32'h00001234, 32'd0);
    waitDone("divu_zero", 1, 2, 1);
    checkOutput("divu_zero_lo", 64'(o_lo), 64'hFFFFFFFF);
    checkOutput("divu_zero_hi", 64'(o_hi), 64'h00001234);
    checkOutput("divu_zero_flag", 64'(o_div0), 64'd1);
    tick();
    checkOutput("div0_sticky", 64'(o_div0), 64'd1);
    issue(F_MULTU, 32'd3, 32'd4);
    checkOutput("div0_cleared", 64'(o_div0), 64'd0);
    waitDone("multu_small", 1, 34, 33);
    checkOutput("multu_small_lo", 64'(o_lo), 64'd12);
    tick();

    // MFHI arriving at T+5 of a MULT stalls until the result is final
    issue(F_MULT, 32'h00010000, 32'h00010000);
    repeat (4) tick();
    applyStimulus(1'b1, F_MFHI, 32'd0, 32'd0, 1'b0, 1'b0);
    stall_cnt = 0;
    for (int k = 5; k <= 33; k++) begin
      stall_cnt += int'(o_stall);
      tick();
    end
    checkOutput("mfhi_stall_cycles", 64'(stall_cnt), 64'd29);
    checkOutput("mfhi_stall_released", 64'(o_stall), 64'd0);
    checkOutput("mfhi_done", 64'(o_done), 64'd1);
    checkOutput("mfhi_new_hi", 64'(o_hilo_data), 64'd1);
    tick();
    applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 1'b0, 1'b0);

    // MTLO while idle, and an MTHI that is blocked by the external stall
    applyStimulus(1'b1, F_MTLO, 32'hA5A5A5A5, 32'd0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    checkOutput("mtlo_write", 64'(o_lo), 64'hA5A5A5A5);
    applyStimulus(1'b1, F_MTHI, 32'h0000DEAD, 32'd0, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    checkOutput("mthi_stalled", 64'(o_hi), 64'd1);

    // Halt for 10 cycles in the middle of a DIVU (100/7 = 14 r 2)
    issue(F_DIVU, 32'd100, 32'd7);
    repeat (4) tick();
    applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    repeat (5) tick();
    checkOutput("halt_busy", 64'(o_busy), 64'd1);
    repeat (5) tick();
    applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    waitDone("halt_div", 15, 44, 29);
    checkOutput("halt_div_lo", 64'(o_lo), 64'd14);
    checkOutput("halt_div_hi", 64'(o_hi), 64'd2);
    tick();

    // Reset at T+12 aborts a MULT
    issue(F_MULT, 32'd9, 32'd9);
    repeat (11) tick();
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    checkOutput("abort_busy", 64'(o_busy), 64'd0);
    checkOutput("abort_hi", 64'(o_hi), 64'd0);
    checkOutput("abort_lo", 64'(o_lo), 64'd0);

    // Held MULTU under external stall is accepted once, after release
    applyStimulus(1'b1, F_MULTU, 32'd5, 32'd6, 1'b1, 1'b0);
    repeat (3) tick();
    checkOutput("stall_no_accept", 64'(o_busy), 64'd0);
    applyStimulus(1'b1, F_MULTU, 32'd5, 32'd6, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    waitDone("stall_mult", 1, 34, 33);
    checkOutput("stall_mult_lo", 64'(o_lo), 64'd30);
    tick();
    checkOutput("stall_single_accept", 64'(o_busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
